isqrt_pipe: RTL and testbench
=============================

Name: isqrt_pipe

Overview:
- Fully pipelined integer square root, y = floor(sqrt(x)), 32-bit x, 16-bit y.
- Sits directly downstream of the formula FSMs: each formula FSM instantiates one or two of these on its isqrt_N_x / isqrt_N_y ports.
- Accepts a new argument every cycle with no backpressure, because the formula FSMs issue arguments without a ready signal.
- Produces results in issue order after a fixed latency.

Parameters:
- n_stages, 16, number of register stages and therefore the latency in cycles; legal values are 1, 2, 4, 8 and 16.
- Each stage resolves 16 / n_stages root bits.

Ports:
- clk    input   1   clock, rising edge.
- rst    input   1   asynchronous reset, active-low (asserted at 0); release is synchronous to clk.
- x_vld  input   1   x is valid this cycle and is captured.
- x      input   32  unsigned radicand; ignored while x_vld = 0.
- y_vld  output  1   y holds a result this cycle; single-cycle pulse per accepted x.
- y      output  16  floor(sqrt(x)) for the x accepted n_stages cycles earlier.

Behaviour:
- Reset (rst = 0): all valid bits clear at once, independent of clk. y_vld = 0, y = 0, all stage data registers = 0.
- Latency:
  - x accepted on edge T appears with y_vld = 1 in the cycle after edge T + n_stages - 1, i.e. exactly n_stages cycles later.
  - Throughput is 1 per cycle.
- Ordering and count:
  - Results leave in acceptance order.
  - Number of y_vld pulses equals number of accepted x.
  - Bubbles on x_vld appear as identical bubbles on y_vld.
- Valid chain: vld[0] <= x_vld; vld[k] <= vld[k-1]; y_vld = vld[n_stages-1]. The chain always advances; there is no stall.
- Data gating: stage k data registers load only when that stage's incoming valid = 1, otherwise they hold. Consequently y stays stable between y_vld pulses (it keeps the last result).
- Algorithm: restoring digit recurrence, MSB first, 16 iterations in total. State per iteration is rem (18 bits unsigned), root (16 bits) and the remaining x bits (32 bits, shifted left 2 per iteration). Starting from rem = 0, root = 0, each iteration does:
  - rem' = {rem[15:0], xs[31:30]}; xs' = xs << 2.
  - trial = {root[15:0], 2'b01}, 18 bits.
  - If rem' >= trial: rem = rem' - trial and root = {root[14:0], 1}; otherwise rem = rem' and root = {root[14:0], 0}.
- Arithmetic: 18-bit compare and subtract, no overflow possible. The final remainder is not an output.
- Boundary values:
  - x = 0 gives 0.
  - x = 32'hFFFF_FFFF gives 16'hFFFF.
  - x = 32'hFFFE_0001 gives 16'hFFFF.
  - x = 32'hFFFE_0000 gives 16'hFFFE.
- Reset mid-operation: every in-flight result is discarded and no y_vld is emitted for it. The first x_vld after release is processed normally.
- Simultaneous events: with x_vld = 1 every cycle, every stage is occupied and all results come out back to back.
- No FSM: the control is the valid shift chain, and the datapath is n_stages registered slices.

Decomposition:
- Package isqrt_pkg holds:
  - isqrt_x_w = 32, isqrt_y_w = 16, isqrt_rem_w = 18.
  - A typedef for the stage state struct {rem, root, xs}.
  - A function isqrt_iter(state) implementing one recurrence iteration.
- Sub-module isqrt_stage (parameter iters_per_stage) contains:
  - the combinational unrolled isqrt_iter iterations;
  - the valid-gated registers and the async-reset valid flop.
- isqrt_pipe instantiates n_stages copies of isqrt_stage with a generate loop.

Test Plan:
- Reset release, then x_vld = 1 with x = 144 on one cycle: y_vld pulses exactly n_stages cycles later with y = 12, and y holds 12 afterwards.
- Back-to-back x = 0, 1, 143, 32'hFFFF_FFFF, 32'hFFFE_0000 on consecutive cycles: five consecutive pulses y = 0, 1, 11, 16'hFFFF, 16'hFFFE.
- x_vld pattern 1,0,0,1,0,1 with x = 4, 9, 16: the y_vld pattern is identical, shifted by n_stages, with y = 2, 3, 4.
- Drive rst = 0 between clock edges while 3 results are in flight: y_vld drops immediately with no clock; after release, no pulse appears for the flushed arguments; then x = 625 gives 25.
- Random 10k x values at random x_vld density, run at n_stages = 1, 4 and 16: each result matches the reference model floor(sqrt(x)), the pulse count equals the accept count, and latency equals n_stages.
- Two instances driven by formula_1_impl_2_fsm with a = 16, b = 25, c = 36: formula res = 15.

Source files
------------

// File: rtl/isqrt_pkg.sv
// isqrt_pkg: widths, stage state and one restoring square-root iteration.
package isqrt_pkg;
  localparam int isqrt_x_w = 32;
  localparam int isqrt_y_w = 16;
  localparam int isqrt_rem_w = 18;
  typedef struct packed {
    logic [isqrt_rem_w-1:0] rem;
    logic [isqrt_y_w-1:0]   root;
    logic [isqrt_x_w-1:0]   xs;
  } isqrt_state_t;
  function automatic isqrt_state_t isqrt_iter(input isqrt_state_t s);
    isqrt_state_t o;
    logic [isqrt_rem_w-1:0] r;
    logic [isqrt_rem_w-1:0] t;
    r = {s.rem[isqrt_rem_w-3:0], s.xs[isqrt_x_w-1 -: 2]};
    t = {s.root, 2'b01};
    o.xs = s.xs << 2;
    o.rem = (r >= t) ? r - t : r;
    o.root = {s.root[isqrt_y_w-2:0], r >= t};
    return o;
  endfunction
endpackage

// File: rtl/isqrt_stage.sv
// isqrt_stage: iters_per_stage unrolled root iterations behind valid-gated registers.
module isqrt_stage
  import isqrt_pkg::*;
#(
  parameter int iters_per_stage = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld_i,
  input  isqrt_state_t st_i,
  output logic         vld_o,
  output isqrt_state_t st_o
);
  isqrt_state_t st_d;
  isqrt_state_t st_q;
  logic vld_q;
  always_comb begin
    st_d = st_i;
    for (int i = 0; i < iters_per_stage; i++) st_d = isqrt_iter(st_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      st_q  <= '0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) st_q <= st_d;
    end
  end
  assign vld_o = vld_q;
  assign st_o  = st_q;
endmodule

// File: rtl/isqrt_pipe.sv
// isqrt_pipe: fully pipelined floor(sqrt(x)), latency n_stages, one result per cycle.
module isqrt_pipe
  import isqrt_pkg::*;
#(
  parameter int n_stages = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 x_vld_i,
  input  logic [isqrt_x_w-1:0] x_i,
  output logic                 y_vld_o,
  output logic [isqrt_y_w-1:0] y_o
);
  isqrt_state_t st [n_stages+1];
  logic vld [n_stages+1];
  logic unused_tail;
  assign st[0]  = '{rem: '0, root: '0, xs: x_i};
  assign vld[0] = x_vld_i;
  for (genvar g = 0; g < n_stages; g++) begin : g_stage
    isqrt_stage #(.iters_per_stage(isqrt_y_w / n_stages)) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .vld_i (vld[g]),
      .st_i  (st[g]),
      .vld_o (vld[g+1]),
      .st_o  (st[g+1])
    );
  end
  assign y_vld_o = vld[n_stages];
  assign y_o     = st[n_stages].root;
  // final remainder and exhausted radicand bits are not outputs
  assign unused_tail = ^{st[n_stages].rem, st[n_stages].xs};
endmodule

// File: tb/tb_isqrt_pipe.sv
// tb_isqrt_pipe: random and directed checks of three pipeline depths against an arithmetic model.
module tb_isqrt_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic x_vld = 1'b0;
  logic [31:0] x = '0;
  logic [2:0] yv;
  logic [2:0][15:0] yy;
  int lat [3] = '{1, 4, 16};
  bit hv [0:16383];
  logic [31:0] hx [0:16383];
  int e = 0;
  logic [15:0] last_y [3];
  int acc [3];
  int pulses [3];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  isqrt_pipe #(.n_stages(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .x_vld_i(x_vld), .x_i(x), .y_vld_o(yv[0]), .y_o(yy[0]));
  isqrt_pipe #(.n_stages(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .x_vld_i(x_vld), .x_i(x), .y_vld_o(yv[1]), .y_o(yy[1]));
  isqrt_pipe #(.n_stages(16)) u_d16 (
    .clk(clk), .rst_n(rst_n), .x_vld_i(x_vld), .x_i(x), .y_vld_o(yv[2]), .y_o(yy[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_sqrt(input logic [31:0] v);
    longint r;
    longint lv;
    lv = longint'(v);
    r = longint'($floor($sqrt(real'(lv))));
    while (r * r > lv) r--;
    while ((r + 1) * (r + 1) <= lv) r++;
    return r[15:0];
  endfunction

  task automatic step(input bit v, input logic [31:0] xv);
    int j;
    bit ev;
    x_vld = v;
    x = xv;
    @(posedge clk);
    hv[e] = v;
    hx[e] = xv;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      j = e - lat[k] + 1;
      ev = (j >= 0) && hv[j];
      if (ev) last_y[k] = ref_sqrt(hx[j]);
      chk($sformatf("y_vld[L=%0d]", lat[k]), {31'b0, yv[k]}, {31'b0, ev});
      chk($sformatf("y[L=%0d]", lat[k]), {16'b0, yy[k]}, {16'b0, last_y[k]});
      if (yv[k]) pulses[k]++;
      if (v) acc[k]++;
    end
    e++;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_y_vld[L=%0d]", lat[k]), {31'b0, yv[k]}, 32'd0);
      chk($sformatf("rst_y[L=%0d]", lat[k]), {16'b0, yy[k]}, 32'd0);
      last_y[k] = '0;
      for (int j = e - lat[k] + 1; j < e; j++) if (j >= 0 && hv[j]) acc[k]--;
    end
    for (int j = 0; j < e; j++) hv[j] = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] b2b [6];
    int dens;
    logic [31:0] s;
    b2b = '{32'd0, 32'd1, 32'd143, 32'hFFFF_FFFF, 32'hFFFE_0000, 32'hFFFE_0001};
    for (int k = 0; k < 3; k++) begin
      last_y[k] = '0;
      acc[k] = 0;
      pulses[k] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("init_y_vld[L=%0d]", lat[k]), {31'b0, yv[k]}, 32'd0);
      chk($sformatf("init_y[L=%0d]", lat[k]), {16'b0, yy[k]}, 32'd0);
    end
    rst_n = 1'b1;
    step(1'b1, 32'd144);
    idle(20);
    for (int i = 0; i < 6; i++) step(1'b1, b2b[i]);
    idle(20);
    step(1'b1, 32'd4); step(1'b0, 32'd7); step(1'b0, 32'd7);
    step(1'b1, 32'd9); step(1'b0, 32'd7); step(1'b1, 32'd16);
    idle(20);
    step(1'b1, 32'd100); step(1'b1, 32'd200); step(1'b1, 32'd300);
    do_reset();
    idle(20);
    step(1'b1, 32'd625);
    idle(20);
    for (int b = 0; b < 10; b++) begin
      dens = int'($urandom_range(0, 100));
      for (int i = 0; i < 1000; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          s = $urandom_range(0, 65535);
          s = s * s - ($urandom_range(0, 1));
        end else s = $urandom;
        step(int'($urandom_range(0, 99)) < dens, s);
      end
    end
    idle(20);
    for (int k = 0; k < 3; k++)
      chk($sformatf("pulse_count[L=%0d]", lat[k]), pulses[k], acc[k]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
